reg_scoreboard: RTL

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

---
 rtl/reg_scoreboard.sv | 93 +++++++++
 1 files changed

// File: rtl/reg_scoreboard.sv
// In-order 4-entry pending-destination scoreboard for long-latency ops.
// Optional SB_RETIRE_BYPASS_EN: retiring head entry skips the stall compare.
module reg_scoreboard (
   input  logic       sys_clk,
   input  logic       reset,
   input  logic       issue,
   input  logic [5:0] issue_reg,
   input  logic       retire,
   input  logic [5:0] srca,
   input  logic [5:0] srcb,
   input  logic       srca_en,
   input  logic       srcb_en,
   input  logic [5:0] dstc,
   input  logic       dstc_en,
   output logic       stall,
   output logic [5:0] retire_reg,
   output logic [2:0] count,
   output logic       full,
   output logic       empty
);

   logic [3:0][5:0] ent_q, ent_n;
   logic [3:0]      vld_q, vld_n;
   logic [1:0]      head_q, head_n;
   logic [1:0]      tail_q, tail_n;
   logic [2:0]      cnt_q, cnt_n;
   logic [5:0]      rr_q, rr_n;
   logic            do_ret;
   logic            do_iss;

   assign do_ret = retire && (cnt_q != 3'd0);
   // A retire in the same cycle frees the slot for an issue at full.
   assign do_iss = issue && ((cnt_q != 3'd4) || do_ret);

   always_comb begin
      ent_n  = ent_q;
      vld_n  = vld_q;
      head_n = head_q;
      tail_n = tail_q;
      if (do_ret) begin
         vld_n[head_q] = 1'b0;
         head_n        = head_q + 2'd1;
      end
      if (do_iss) begin
         ent_n[tail_q] = issue_reg;
         vld_n[tail_q] = 1'b1;
         tail_n        = tail_q + 2'd1;
      end
      cnt_n = cnt_q + {2'b00, do_iss} - {2'b00, do_ret};
      rr_n  = vld_n[head_n] ? ent_n[head_n] : 6'd0;
   end

   always_ff @(posedge sys_clk) begin
      if (reset) begin
         ent_q  <= '0;
         vld_q  <= '0;
         head_q <= 2'd0;
         tail_q <= 2'd0;
         cnt_q  <= 3'd0;
         rr_q   <= 6'd0;
      end else begin
         ent_q  <= ent_n;
         vld_q  <= vld_n;
         head_q <= head_n;
         tail_q <= tail_n;
         cnt_q  <= cnt_n;
         rr_q   <= rr_n;
      end
   end

   always_comb begin
      stall = 1'b0;
      for (int i = 0; i < 4; i++) begin
         logic hit;
         logic live;
         hit = (srca_en && (ent_q[i] == srca))
            || (srcb_en && (ent_q[i] == srcb))
            || (dstc_en && (ent_q[i] == dstc));
`ifdef SB_RETIRE_BYPASS_EN
         live = vld_q[i] && !(do_ret && (head_q == 2'(i)));
`else
         live = vld_q[i];
`endif
         if (live && hit) stall = 1'b1;
      end
   end

   assign retire_reg = rr_q;
   assign count      = cnt_q;
   assign full       = (cnt_q == 3'd4);
   assign empty      = (cnt_q == 3'd0);

endmodule
